// File: rtl/laser_safety_sequencer.sv
// Laser power-enable / TA shutdown sequencer: qualifies power, waits out settle time,
// arms, and latches faults through a clear, cooldown and retry-limited lockout sequence.
module laser_safety_sequencer #(
  parameter int PWR_SETTLE_CYCLES = 25000,
  parameter int COOLDOWN_CYCLES   = 250000,
  parameter int MAX_RETRIES       = 3,
  parameter int CNT_W             = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arm,
  input  logic       enable_error_check,
  input  logic       pwr_good,
  input  logic [3:0] fault_vec,
  input  logic       clear_fail,
  output logic       laser_pwr_en,
  output logic       ta_shutdown,
  output logic [2:0] state,
  output logic [4:0] fault_latched,
  output logic [1:0] retry_count,
  output logic       lockout
);

  localparam logic [2:0] ST_OFF      = 3'd0;
  localparam logic [2:0] ST_SETTLE   = 3'd1;
  localparam logic [2:0] ST_ARMED    = 3'd2;
  localparam logic [2:0] ST_FAULT    = 3'd3;
  localparam logic [2:0] ST_COOLDOWN = 3'd4;
  localparam logic [2:0] ST_LOCKOUT  = 3'd5;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(PWR_SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOL_LAST   = CNT_W'(COOLDOWN_CYCLES - 1);
  localparam logic [1:0]       RETRY_LIMIT = 2'(MAX_RETRIES);

  logic [2:0]       state_next;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_next;
  logic [4:0]       latched_next;
  logic [1:0]       retry_next;
  logic             lf;

  // Priority inside each state: live fault, then arm release, then timer expiry, then clear.
  always_comb begin
    lf           = ((|fault_vec) & enable_error_check) | ~pwr_good;
    state_next   = state;
    retry_next   = retry_count;
    latched_next = fault_latched;
    case (state)
      ST_OFF: begin
        if (arm && pwr_good) state_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (lf)                       state_next = ST_FAULT;
        else if (!arm)                state_next = ST_OFF;
        else if (timer == SETTLE_LAST) state_next = ST_ARMED;
      end
      ST_ARMED: begin
        if (lf) begin
          state_next = ST_FAULT;
          if (retry_count != 2'd3) retry_next = retry_count + 2'd1;
        end else if (!arm) begin
          state_next = ST_OFF;
        end
      end
      ST_FAULT: begin
        if (!lf && clear_fail)
          state_next = (retry_count >= RETRY_LIMIT) ? ST_LOCKOUT : ST_COOLDOWN;
      end
      ST_COOLDOWN: begin
        if (timer == COOL_LAST) begin
          state_next   = ST_OFF;
          latched_next = 5'd0;
        end
      end
      ST_LOCKOUT: begin
        state_next = ST_LOCKOUT;
      end
      default: begin
        state_next      = ST_FAULT;
        latched_next[4] = 1'b1;
      end
    endcase

    // Fault causes accumulate on entry and on every cycle spent in FAULT.
    if (state_next == ST_FAULT)
      latched_next = latched_next | {~pwr_good, fault_vec & {4{enable_error_check}}};

    timer_next = '0;
    if ((state_next == state) && ((state == ST_SETTLE) || (state == ST_COOLDOWN)))
      timer_next = timer + CNT_W'(1);
  end

  // Outputs are decoded from the next state so they change on the transition edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_OFF;
      timer         <= '0;
      fault_latched <= 5'd0;
      retry_count   <= 2'd0;
      laser_pwr_en  <= 1'b0;
      ta_shutdown   <= 1'b1;
      lockout       <= 1'b0;
    end else begin
      state         <= state_next;
      timer         <= timer_next;
      fault_latched <= latched_next;
      retry_count   <= retry_next;
      laser_pwr_en  <= (state_next == ST_SETTLE) || (state_next == ST_ARMED);
      ta_shutdown   <= (state_next != ST_ARMED);
      lockout       <= (state_next == ST_LOCKOUT);
    end
  end

endmodule

// File: tb/tb_laser_safety_sequencer.sv
// Scoreboard bench for laser_safety_sequencer with short settle/cooldown times and
// a two-fault retry limit; expected state/latch/retry values are pushed per stimulus cycle.
module tb_laser_safety_sequencer;

  localparam int PWR_SETTLE_CYCLES = 8;
  localparam int COOLDOWN_CYCLES   = 16;
  localparam int MAX_RETRIES       = 2;
  localparam int CNT_W             = 5;

  localparam logic [2:0] S_OFF = 3'd0, S_SETTLE = 3'd1, S_ARMED = 3'd2,
                         S_FAULT = 3'd3, S_COOL = 3'd4, S_LOCK = 3'd5;

  logic       clk = 1'b0;
  logic       rst;
  logic       arm;
  logic       enable_error_check;
  logic       pwr_good;
  logic [3:0] fault_vec;
  logic       clear_fail;
  logic       laser_pwr_en;
  logic       ta_shutdown;
  logic [2:0] state;
  logic [4:0] fault_latched;
  logic [1:0] retry_count;
  logic       lockout;

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic [4:0] lat;
    logic [1:0] rc;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  laser_safety_sequencer #(
    .PWR_SETTLE_CYCLES(PWR_SETTLE_CYCLES),
    .COOLDOWN_CYCLES  (COOLDOWN_CYCLES),
    .MAX_RETRIES      (MAX_RETRIES),
    .CNT_W            (CNT_W)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .arm               (arm),
    .enable_error_check(enable_error_check),
    .pwr_good          (pwr_good),
    .fault_vec         (fault_vec),
    .clear_fail        (clear_fail),
    .laser_pwr_en      (laser_pwr_en),
    .ta_shutdown       (ta_shutdown),
    .state             (state),
    .fault_latched     (fault_latched),
    .retry_count       (retry_count),
    .lockout           (lockout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Inputs are already set by the caller; one clock edge is applied per call.
  task automatic applyStimulus(input string tag, input logic [2:0] st,
                               input logic [4:0] lat, input logic [1:0] rc);
    exp_t e;
    e.tag = tag;
    e.st  = st;
    e.lat = lat;
    e.rc  = rc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checkOutput({e.tag, ".state"},   32'(state),         32'(e.st));
    checkOutput({e.tag, ".latched"}, 32'(fault_latched), 32'(e.lat));
    checkOutput({e.tag, ".retry"},   32'(retry_count),   32'(e.rc));
    checkOutput({e.tag, ".pwr_en"},  32'(laser_pwr_en),
                32'((e.st == S_SETTLE) || (e.st == S_ARMED)));
    checkOutput({e.tag, ".ta_sd"},   32'(ta_shutdown),   32'(e.st != S_ARMED));
    checkOutput({e.tag, ".lockout"}, 32'(lockout),       32'(e.st == S_LOCK));
  endtask

  task automatic settleToArmed(input string tag, input logic [1:0] rc);
    for (int i = 0; i < PWR_SETTLE_CYCLES - 1; i++)
      applyStimulus({tag, "_settle"}, S_SETTLE, 5'd0, rc);
    applyStimulus({tag, "_armed"}, S_ARMED, 5'd0, rc);
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; enable_error_check = 1'b1; pwr_good = 1'b1;
    fault_vec = 4'd0; clear_fail = 1'b0;
    applyStimulus("reset", S_OFF, 5'd0, 2'd0);

    rst = 1'b0; arm = 1'b1;
    applyStimulus("arm_entry", S_SETTLE, 5'd0, 2'd0);
    settleToArmed("arm1", 2'd0);
    applyStimulus("armed_hold", S_ARMED, 5'd0, 2'd0);

    fault_vec = 4'b0010;
    applyStimulus("pulse_fault", S_FAULT, 5'b00010, 2'd1);

    fault_vec = 4'b0100; clear_fail = 1'b1;
    applyStimulus("clear_blocked", S_FAULT, 5'b00110, 2'd1);
    clear_fail = 1'b0;
    applyStimulus("fault_hold", S_FAULT, 5'b00110, 2'd1);
    fault_vec = 4'd0;
    applyStimulus("no_clear_memory", S_FAULT, 5'b00110, 2'd1);
    clear_fail = 1'b1;
    applyStimulus("clear_accept", S_COOL, 5'b00110, 2'd1);
    clear_fail = 1'b0;

    for (int i = 0; i < COOLDOWN_CYCLES - 1; i++) begin
      clear_fail = (i == 3);
      fault_vec  = (i == 6) ? 4'b1000 : 4'd0;
      applyStimulus("cooldown", S_COOL, 5'b00110, 2'd1);
    end
    clear_fail = 1'b0; fault_vec = 4'd0;
    applyStimulus("cool_exit", S_OFF, 5'd0, 2'd1);
    applyStimulus("rearm_entry", S_SETTLE, 5'd0, 2'd1);
    settleToArmed("arm2", 2'd1);

    enable_error_check = 1'b0; fault_vec = 4'b1111;
    applyStimulus("masked1", S_ARMED, 5'd0, 2'd1);
    applyStimulus("masked2", S_ARMED, 5'd0, 2'd1);
    pwr_good = 1'b0;
    applyStimulus("pwr_loss", S_FAULT, 5'b10000, 2'd2);
    pwr_good = 1'b1; fault_vec = 4'd0; enable_error_check = 1'b1;
    applyStimulus("pwr_back", S_FAULT, 5'b10000, 2'd2);
    clear_fail = 1'b1;
    applyStimulus("lockout_entry", S_LOCK, 5'b10000, 2'd2);
    clear_fail = 1'b0;
    applyStimulus("lockout_arm", S_LOCK, 5'b10000, 2'd2);
    clear_fail = 1'b1;
    applyStimulus("lockout_clear", S_LOCK, 5'b10000, 2'd2);
    clear_fail = 1'b0;

    rst = 1'b1; arm = 1'b0;
    applyStimulus("lockout_rst", S_OFF, 5'd0, 2'd0);
    rst = 1'b0; arm = 1'b1;
    applyStimulus("arm3_entry", S_SETTLE, 5'd0, 2'd0);
    settleToArmed("arm3", 2'd0);

    fault_vec = 4'b1000; arm = 1'b0;
    applyStimulus("fault_vs_disarm", S_FAULT, 5'b01000, 2'd1);
    fault_vec = 4'd0; clear_fail = 1'b1;
    applyStimulus("clear3", S_COOL, 5'b01000, 2'd1);
    clear_fail = 1'b0; rst = 1'b1;
    applyStimulus("cool_rst", S_OFF, 5'd0, 2'd0);

    rst = 1'b0; arm = 1'b1;
    applyStimulus("arm4_entry", S_SETTLE, 5'd0, 2'd0);
    applyStimulus("arm4_settle", S_SETTLE, 5'd0, 2'd0);
    rst = 1'b1;
    applyStimulus("settle_rst", S_OFF, 5'd0, 2'd0);

    rst = 1'b0;
    applyStimulus("arm5_entry", S_SETTLE, 5'd0, 2'd0);
    fault_vec = 4'b0001;
    applyStimulus("settle_fault", S_FAULT, 5'b00001, 2'd0);
    fault_vec = 4'd0; arm = 1'b0;
    applyStimulus("settle_fault_hold", S_FAULT, 5'b00001, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
